// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MCPU: FSM state codes, MIPS opcode/funct
// values, ALU operation codes and datapath mux select encodings.
package mcpu_pkg;

  typedef enum logic [4:0] {
    S_IF  = 5'd0,
    S_ID  = 5'd1,
    S_MA  = 5'd2,
    S_MR  = 5'd3,
    S_LWB = 5'd4,
    S_MW  = 5'd5,
    S_RX  = 5'd6,
    S_RWB = 5'd7,
    S_BEQ = 5'd8,
    S_J   = 5'd9,
    S_IX  = 5'd10,
    S_IWB = 5'd11,
    S_LUI = 5'd12,
    S_BNE = 5'd13,
    S_JR  = 5'd14,
    S_JAL = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_LUI    = 2'b10;
  localparam logic [1:0] WB_PC     = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // Decode-state dispatch; unrecognised encodings fall back to fetch as a nop.
  function automatic state_t id_dispatch(input logic [5:0] opcode, input logic [5:0] funct);
    state_t nxt;
    nxt = S_IF;
    case (opcode)
      OP_LW, OP_SW: nxt = S_MA;
      OP_RTYPE: begin
        if (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SRL}) nxt = S_RX;
        else if (funct == F_JR) nxt = S_JR;
      end
      OP_BEQ: nxt = S_BEQ;
      OP_BNE: nxt = S_BNE;
      OP_J:   nxt = S_J;
      OP_JAL: nxt = S_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_IX;
      OP_LUI: nxt = S_LUI;
      default: nxt = S_IF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: ADD everywhere except the execute states, where the op
// comes from funct (R-type), opcode (I-type) or is SUB (branch compare).
module alu_dec
  import mcpu_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (state_i)
      S_RX: begin
        case (funct_i)
          F_SUB:   alu_op_o = ALU_SUB;
          F_AND:   alu_op_o = ALU_AND;
          F_OR:    alu_op_o = ALU_OR;
          F_XOR:   alu_op_o = ALU_XOR;
          F_NOR:   alu_op_o = ALU_NOR;
          F_SLT:   alu_op_o = ALU_SLT;
          F_SRL:   alu_op_o = ALU_SRL;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      S_BEQ, S_BNE: alu_op_o = ALU_SUB;
      S_IX: begin
        case (opcode_i)
          OP_SLTI: alu_op_o = ALU_SLT;
          OP_ANDI: alu_op_o = ALU_AND;
          OP_ORI:  alu_op_o = ALU_OR;
          OP_XORI: alu_op_o = ALU_XOR;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/m_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and Moore-decodes the datapath controls from the current state.
module m_ctrl
  import mcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  input  logic [31:0] Inst_in,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        ALUSrcA,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out
);

  state_t     state_q;
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = Inst_in[31:26];
  assign funct  = Inst_in[5:0];

  // Branch resolution and overflow handling live in the datapath.
  logic unused_inputs;
  assign unused_inputs = ^{zero, overflow, Inst_in[25:6]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF:    if (MIO_ready) state_q <= S_ID;
        S_ID:    state_q <= id_dispatch(opcode, funct);
        S_MA:    state_q <= (opcode == OP_SW) ? S_MW : S_MR;
        S_MR:    if (MIO_ready) state_q <= S_LWB;
        S_MW:    if (MIO_ready) state_q <= S_IF;
        S_RX:    state_q <= S_RWB;
        S_IX:    state_q <= S_IWB;
        default: state_q <= S_IF;
      endcase
    end
  end

  assign state_out = state_q;

  alu_dec u_alu_dec (
    .state_i  (state_q),
    .opcode_i (opcode),
    .funct_i  (funct),
    .alu_op_o (ALU_operation)
  );

  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    CPU_MIO     = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    ALUSrcA     = 1'b0;
    Branch      = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = WB_ALUOUT;
    ALUSrcB     = SRCB_RT;
    PCSource    = PCSRC_ALU;
    case (state_q)
      S_IF: begin
        // IR and PC+4 only commit on the cycle memory delivers the word.
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
      end
      S_ID: ALUSrcB = SRCB_BRANCH;
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MR: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        IorD    = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = WB_MDR;
      end
      S_MW: begin
        MemWrite = 1'b1;
        CPU_MIO  = 1'b1;
        IorD     = 1'b1;
      end
      S_RX: ALUSrcA = 1'b1;
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        Branch      = (state_q == S_BEQ);
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_IX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_IWB: RegWrite = 1'b1;
      S_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = WB_LUI;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_RS;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = WB_PC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m_ctrl.sv
// Bench for m_ctrl: per-instruction state paths and a control table give the
// expected outputs for every cycle; literal checks pin the model itself.
module tb_m_ctrl;

  typedef struct packed {
    logic [4:0] st;
    logic       mem_read, mem_write, cpu_mio, iord, ir_write;
    logic       reg_write, pc_write, pc_write_cond, alu_src_a, branch;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
  } ctl_t;

  typedef int st_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0;
  logic [31:0] Inst_in = 32'h0;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond;
  logic        ALUSrcA, Branch;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;

  logic [25:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  m_ctrl dut (
    .clk(clk), .reset(reset), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
    .Inst_in(Inst_in), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
    .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA), .Branch(Branch), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_operation(ALU_operation), .state_out(state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic st_q_t path_of(input logic [31:0] inst);
    st_q_t p;
    logic [5:0] op, fn;
    op = inst[31:26];
    fn = inst[5:0];
    p.push_back(0);
    p.push_back(1);
    case (op)
      6'h23: begin p.push_back(2); p.push_back(3); p.push_back(4); end
      6'h2B: begin p.push_back(2); p.push_back(5); end
      6'h00: begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02}) begin
          p.push_back(6); p.push_back(7);
        end else if (fn == 6'h08) p.push_back(14);
      end
      6'h04: p.push_back(8);
      6'h05: p.push_back(13);
      6'h02: p.push_back(9);
      6'h03: p.push_back(15);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin p.push_back(10); p.push_back(11); end
      6'h0F: p.push_back(12);
      default: ;
    endcase
    return p;
  endfunction

  function automatic ctl_t exp_out(input int s, input logic mio, input logic [31:0] inst);
    ctl_t c;
    c = '0;
    c.st = 5'(s);
    c.alu_op = 3'b010;
    case (s)
      0: begin c.mem_read = 1; c.cpu_mio = 1; c.alu_src_b = 2'b01; c.ir_write = mio; c.pc_write = mio; end
      1: c.alu_src_b = 2'b11;
      2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3: begin c.mem_read = 1; c.cpu_mio = 1; c.iord = 1; end
      4: begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      5: begin c.mem_write = 1; c.cpu_mio = 1; c.iord = 1; end
      6: begin
        c.alu_src_a = 1;
        case (inst[5:0])
          6'h22: c.alu_op = 3'b110;
          6'h24: c.alu_op = 3'b000;
          6'h25: c.alu_op = 3'b001;
          6'h26: c.alu_op = 3'b011;
          6'h27: c.alu_op = 3'b100;
          6'h2A: c.alu_op = 3'b111;
          6'h02: c.alu_op = 3'b101;
          default: c.alu_op = 3'b010;
        endcase
      end
      7: begin c.reg_write = 1; c.reg_dst = 2'b01; end
      8, 13: begin
        c.alu_src_a = 1; c.alu_op = 3'b110; c.pc_write_cond = 1;
        c.pc_source = 2'b01; c.branch = (s == 8);
      end
      9: begin c.pc_write = 1; c.pc_source = 2'b10; end
      10: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        case (inst[31:26])
          6'h0A: c.alu_op = 3'b111;
          6'h0C: c.alu_op = 3'b000;
          6'h0D: c.alu_op = 3'b001;
          6'h0E: c.alu_op = 3'b011;
          default: c.alu_op = 3'b010;
        endcase
      end
      11: c.reg_write = 1;
      12: begin c.reg_write = 1; c.mem_to_reg = 2'b10; end
      14: begin c.pc_write = 1; c.pc_source = 2'b11; end
      15: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b11; end
      default: ;
    endcase
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rst, input logic mio, input logic [31:0] inst, input int s);
    @(posedge clk);
    #1;
    reset     = rst;
    MIO_ready = mio;
    Inst_in   = inst;
    zero      = 1'($urandom_range(0, 1));
    overflow  = 1'($urandom_range(0, 1));
    exp_q.push_back(exp_out(s, mio, inst));
  endtask

  task automatic run_instr(input logic [31:0] inst, input int if_stall, input int mem_stall);
    st_q_t p;
    p = path_of(inst);
    foreach (p[i]) begin
      int n;
      logic waits;
      waits = (p[i] == 0) || (p[i] == 3) || (p[i] == 5);
      n = (p[i] == 0) ? if_stall : (waits ? mem_stall : 0);
      repeat (n) cycle(1'b1, 1'b0, inst, p[i]);
      cycle(1'b1, waits ? 1'b1 : 1'($urandom_range(0, 1)), inst, p[i]);
    end
  endtask

  task automatic check_pin(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h", name, got, want);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ctl_t e, a;
      e = exp_q.pop_front();
      a = {state_out, MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite,
           PCWriteCond, ALUSrcA, Branch, RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation};
      total_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL ctl_cycle t=%0t exp_state=%0d got=%h expected=%h", $time, e.st, a, e);
    end
  end

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    return {6'h00, 5'd18, 5'd19, 5'd17, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op);
    return {op, 5'd18, 5'd17, 16'h8001};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ctl_t c;
    st_q_t p;

    // Literal pins on the model, hand-derived from the control table.
    p = path_of(32'h8E520000);
    check_pin("lw_path_len", p.size(), 5);
    check_pin("lw_path_last", p[4], 4);
    check_pin("unsup_path_len", path_of(32'h00100000).size(), 2);
    check_pin("sw_path_len", path_of(32'hAE520000).size(), 4);
    c = exp_out(4, 1'b1, 32'h8E520000);
    check_pin("lwb_ctl", {c.reg_write, c.mem_to_reg, c.reg_dst}, 32'b10100);
    c = exp_out(6, 1'b1, 32'h02538822);
    check_pin("sub_alu", c.alu_op, 3'b110);
    c = exp_out(8, 1'b1, 32'h12520004);
    check_pin("beq_ctl", {c.pc_write_cond, c.branch, c.pc_source}, 32'b1101);
    c = exp_out(15, 1'b1, 32'h0C000000);
    check_pin("jal_ctl", {c.pc_write, c.reg_dst, c.mem_to_reg}, 32'b11011);
    c = exp_out(0, 1'b1, 32'h0);
    check_pin("if_ctl", {c.mem_read, c.ir_write, c.pc_write}, 32'b111);

    // Reset asserted with memory not ready: IF with no write enables.
    #1 reset = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 32'h0, 0);

    run_instr(32'h8E520000, 0, 0);  // lw
    run_instr(32'h8E520000, 1, 2);  // lw with fetch and read stalls
    run_instr(32'hAE520000, 0, 2);  // sw held two cycles in MW
    run_instr(32'h02538822, 0, 0);  // sub
    run_instr(mk_r(6'h20), 0, 0);
    run_instr(mk_r(6'h24), 0, 0);
    run_instr(mk_r(6'h25), 0, 0);
    run_instr(mk_r(6'h26), 0, 0);
    run_instr(mk_r(6'h27), 0, 0);
    run_instr(mk_r(6'h2A), 0, 0);
    run_instr(mk_r(6'h02), 0, 0);
    run_instr(32'h03E00008, 0, 0);  // jr
    run_instr(32'h12520004, 0, 0);  // beq
    run_instr(32'h16720002, 0, 0);  // bne
    run_instr(32'h08000010, 0, 0);  // j
    run_instr(32'h0C000000, 0, 0);  // jal
    run_instr(mk_i(6'h08), 0, 0);
    run_instr(mk_i(6'h0A), 0, 0);
    run_instr(mk_i(6'h0C), 2, 0);
    run_instr(mk_i(6'h0D), 0, 0);
    run_instr(mk_i(6'h0E), 0, 0);
    run_instr(mk_i(6'h0F), 0, 0);   // lui
    run_instr(32'h00100000, 0, 0);  // unsupported funct
    run_instr(32'hFC000000, 0, 0);  // unsupported opcode

    // Abort a lw while it waits in MR.
    cycle(1'b1, 1'b1, 32'h8E520000, 0);
    cycle(1'b1, 1'b1, 32'h8E520000, 1);
    cycle(1'b1, 1'b1, 32'h8E520000, 2);
    cycle(1'b1, 1'b0, 32'h8E520000, 3);
    cycle(1'b0, 1'b0, 32'h8E520000, 0);
    cycle(1'b0, 1'b0, 32'h8E520000, 0);
    run_instr(32'h02538822, 0, 0);

    @(negedge clk);
    #1;
    check_pin("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/m_ctrl.md
# m_ctrl

Multi-cycle MIPS control unit for the MCPU core. A state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux select, write enable and the ALU operation code from the latched instruction (`Inst_in`, the IR contents) and the memory-ready handshake. It sits between the instruction register and the datapath/memory interface.

## Interface
Parameters: none. Clock and reset use one clock; reset is asynchronous and active-low, with port names as the codebase uses them.
- `clk` in 1: system clock; all state changes happen on its rising edge.
- `reset` in 1: asynchronous, active-low; forces the state to IF.
- `zero` in 1: ALU zero flag; consumed by the datapath branch logic, not used by the controller.
- `overflow` in 1: ALU overflow; reserved and ignored (no exception).
- `MIO_ready` in 1: memory access completes this cycle.
- `Inst_in` in 32: current IR contents.
- `MemRead`, `MemWrite`, `CPU_MIO` out 1: memory read strobe, memory write strobe, and memory-access-in-progress.
- `IorD` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `IRWrite`, `RegWrite`, `PCWrite`, `PCWriteCond` out 1: write enables.
- `ALUSrcA` out 1: ALU A input; 0 = PC, 1 = rs.
- `Branch` out 1: branch sense; 1 = beq (taken when zero), 0 = bne (taken when ~zero).
- `RegDst` out 2: destination register; 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` out 2: write-back source; 00 = ALUOut, 01 = MDR, 10 = {imm16, 16'b0}, 11 = PC (link).
- `ALUSrcB` out 2: ALU B input; 00 = rt, 01 = 4, 10 = extended imm, 11 = sign-extended imm << 2.
- `PCSource` out 2: next-PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- `ALU_operation` out 3: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT.
- `state_out` out 5: current state code.

## Operation
Outputs are Moore decodes of the state, with two exceptions: the ALU op in execute states depends on `Inst_in`, and the fetch/memory strobes depend on `MIO_ready`. Any output not listed for a state is 0; `ALU_operation` defaults to ADD.

States and transitions:
- IF (0): MemRead=1, CPU_MIO=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00. IRWrite and PCWrite both equal `MIO_ready`. Go to ID when `MIO_ready`; otherwise stay.
- ID (1): ALUSrcA=0, ALUSrcB=11, ADD (precomputes the branch target). Dispatch on the opcode:
  - lw or sw goes to MA.
  - R-type with a supported funct goes to RX: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010, srl 000010.
  - jr (funct 001000) goes to JR.
  - beq goes to BEQ; bne goes to BNE; j goes to J; jal goes to JAL.
  - addi, slti, andi, ori, xori go to IX.
  - lui goes to LUI.
  - Anything else returns to IF (executes as a nop).
- MA (2): ALUSrcA=1, ALUSrcB=10, ADD. Go to MR for lw, MW for sw.
- MR (3): MemRead=1, CPU_MIO=1, IorD=1. Go to LWB when `MIO_ready`; otherwise stay.
- LWB (4): RegWrite=1, RegDst=00, MemtoReg=01. Go to IF.
- MW (5): MemWrite=1, CPU_MIO=1, IorD=1. Go to IF when `MIO_ready`; otherwise stay.
- RX (6): ALUSrcA=1, ALUSrcB=00, ALU op decoded from funct. Go to RWB.
- RWB (7): RegWrite=1, RegDst=01, MemtoReg=00. Go to IF.
- BEQ (8) and BNE (13): ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01; Branch=1 for BEQ, 0 for BNE. Go to IF.
- J (9): PCWrite=1, PCSource=10. Go to IF.
- IX (10): ALUSrcA=1, ALUSrcB=10. ALU op by opcode: addi ADD, slti SLT, andi AND, ori OR, xori XOR. Go to IWB.
- IWB (11): RegWrite=1, RegDst=00, MemtoReg=00. Go to IF.
- LUI (12): RegWrite=1, RegDst=00, MemtoReg=10. Go to IF.
- JR (14): PCWrite=1, PCSource=11. Go to IF.
- JAL (15): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11. Go to IF.

Immediate extension (sign vs zero) is the datapath's job.

## Timing
- Reset asserted: state becomes IF immediately, `state_out` = 0, and outputs take the IF values.
- Cycles per instruction with `MIO_ready` held high: lw 5; sw, R-type and I-type 4; lui, beq, bne, j, jal and jr 3; unsupported 2.
- Each low cycle of `MIO_ready` in IF, MR or MW adds one cycle. No write enable fires while waiting.
- Reset asserted mid-instruction aborts the instruction. No further enables are issued after reset.

## Structure
- Shared package `mcpu_pkg`: state codes, opcode/funct constants, ALU op codes, and the mux select encodings.
- One sub-module, `alu_dec`: maps state, opcode and funct to `ALU_operation`.

## Test plan
- Reset low, then high, with `MIO_ready`=1: `state_out`=0 and MemRead=IRWrite=PCWrite=1.
- `Inst_in`=0x8E520000 (lw): states 0→1→2→3→4→0. In state 4: RegWrite=1, MemtoReg=01, RegDst=00.
- `Inst_in`=0x02538822 (sub): states 0,1,6,7. In state 6: ALU_operation=110. In state 7: RegDst=01 and RegWrite=1.
- `Inst_in`=0x12520004 (beq) gives state 8 with PCWriteCond=1, Branch=1, PCSource=01. `Inst_in`=0x16720002 (bne) gives state 13 with Branch=0.
- `Inst_in`=0x0C000000 (jal): state 15 with PCWrite=1, RegDst=10, MemtoReg=11. `Inst_in`=0x03E00008 (jr): state 14 with PCSource=11.
- sw with `MIO_ready`=0 for 2 cycles in state 5: MemWrite stays 1 and the FSM holds, then moves to state 0. `Inst_in`=0x00100000 (unsupported): 0→1→0.
